// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display blocks: scan state encoding,
// the blank pattern and active-high hex glyphs ordered {dp,g,f,e,d,c,b,a}.
package sevenseg_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] pat;
        pat = SEG_OFF;
        case (value)
            4'h0: pat = 8'h3F;
            4'h1: pat = 8'h06;
            4'h2: pat = 8'h5B;
            4'h3: pat = 8'h4F;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'h6D;
            4'h6: pat = 8'h7D;
            4'h7: pat = 8'h07;
            4'h8: pat = 8'h7F;
            4'h9: pat = 8'h6F;
            4'hA: pat = 8'h77;
            4'hB: pat = 8'h7C;
            4'hC: pat = 8'h39;
            4'hD: pat = 8'h5E;
            4'hE: pat = 8'h79;
            4'hF: pat = 8'h71;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_frame_buf.sv
// Double-buffered digit patterns and enable mask: writes land in the shadow copy,
// and the active copy seen by the scanner only changes on a commit.
module seg_frame_buf
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    localparam int AW = $clog2(N_DIGITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     mask_wr,
    input  logic [N_DIGITS-1:0]      mask_data,
    input  logic                     commit,
    output logic [N_DIGITS-1:0][7:0] active_pat,
    output logic [N_DIGITS-1:0]      active_mask
);

    logic [N_DIGITS-1:0][7:0] shadow_pat;
    logic [N_DIGITS-1:0]      shadow_mask;

    // Commit copies the shadow as it stood before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_pat  <= {N_DIGITS{SEG_OFF}};
            active_pat  <= {N_DIGITS{SEG_OFF}};
            shadow_mask <= '1;
            active_mask <= '1;
        end else begin
            if (commit) begin
                active_pat  <= shadow_pat;
                active_mask <= shadow_mask;
            end
            for (int i = 0; i < N_DIGITS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    shadow_pat[i] <= wr_data;
                end
            end
            if (mask_wr) begin
                shadow_mask <= mask_data;
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
//   state    | meaning
//   ST_BLANK | all anodes off, anti-ghosting gap before the next digit
//   ST_DRIVE | current digit's anode on (if enabled) with its pattern
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DWELL_CYCLES   = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    localparam int AW = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                mask_wr,
    input  logic [N_DIGITS-1:0] mask_data,
    output logic [7:0]          seg_out,
    output logic [N_DIGITS-1:0] an_out,
    output logic [AW-1:0]       digit_idx,
    output logic                frame_tick
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(N_DIGITS - 1);
    localparam logic [7:0]    SEG_IDLE   = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    scan_state_t              state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [AW-1:0]            idx_nxt;
    logic                     wrap;
    logic [N_DIGITS-1:0]      an_nxt;
    logic [7:0]               seg_nxt;
    logic [N_DIGITS-1:0][7:0] active_pat;
    logic [N_DIGITS-1:0]      active_mask;

    seg_frame_buf #(.N_DIGITS(N_DIGITS)) u_frame_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mask_wr     (mask_wr),
        .mask_data   (mask_data),
        .commit      (wrap),
        .active_pat  (active_pat),
        .active_mask (active_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            digit_idx  <= '0;
            an_out     <= '1;
            seg_out    <= SEG_IDLE;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            an_out     <= an_nxt;
            seg_out    <= SEG_ACTIVE_LOW ? ~seg_nxt : seg_nxt;
            frame_tick <= wrap;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = digit_idx;
        wrap      = 1'b0;
        an_nxt    = '1;
        seg_nxt   = SEG_OFF;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    if (digit_idx == IDX_LAST) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = digit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
            end
        endcase
        if ((state_nxt == ST_DRIVE) && active_mask[digit_idx]) begin
            an_nxt[digit_idx] = 1'b0;
            seg_nxt           = active_pat[digit_idx];
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: a frame-position model predicts every output cycle,
// expectations are queued at each clock edge and compared half a cycle later.
module tb_sevenseg_scan_ctrl;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int DP = DW + BL;
    localparam int FP = N * DP;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic [7:0] seg_out;
    logic [3:0] an_out;
    logic [1:0] digit_idx;
    logic       frame_tick;

    sevenseg_scan_ctrl #(
        .N_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         k = 0;
    logic [7:0] m_shadow[N];
    logic [7:0] m_active[N];
    logic [3:0] m_smask;
    logic [3:0] m_amask;
    int         seen_80 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    // Model of one clock edge, using the inputs as they were just before the edge.
    task automatic model_edge();
        exp_t e;
        int   q, d, off;
        if (rst) begin
            k = 0;
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 8'h00;
                m_active[i] = 8'h00;
            end
            m_smask = 4'hF;
            m_amask = 4'hF;
        end else begin
            k++;
            if (k % FP == 0) begin
                for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                m_amask = m_smask;
            end
            if (wr_en) m_shadow[wr_addr] = wr_data;
            if (mask_wr) m_smask = mask_data;
        end
        q      = k % FP;
        d      = q / DP;
        off    = q % DP;
        e.idx  = d[1:0];
        e.tick = (k != 0) && (q == 0);
        if (off >= BL && m_amask[d]) begin
            e.an  = ~(4'b0001 << d);
            e.seg = ~m_active[d];
        end else begin
            e.an  = 4'b1111;
            e.seg = 8'hFF;
        end
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e = sb.pop_front();
        check("an_out", 32'(an_out), 32'(e.an));
        check("seg_out", 32'(seg_out), 32'(e.seg));
        check("digit_idx", 32'(digit_idx), 32'(e.idx));
        check("frame_tick", 32'(frame_tick), 32'(e.tick));
        if (an_out == 4'b1011 && seg_out == 8'h80) seen_80++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_pat(input logic [1:0] a, input logic [7:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] pats[4];
        int         found;
        pats = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        mask_wr = 1'b0; mask_data = '0;

        // reset held, then release; first digit appears after the blank gap
        run(3);
        rst = 1'b0;
        run(2);
        check("first_drive_an", 32'(an_out), 32'(4'b1110));

        // preload all four digits and watch two full frames
        for (int i = 0; i < N; i++) write_pat(2'(i), pats[i]);
        run(2 * FP);

        // mid-frame write to digit 2 during digit 0 dwell
        found = 0;
        for (int i = 0; i < 2 * FP && found == 0; i++) begin
            step();
            if ((k % FP) == BL + 1) found = 1;
        end
        check("sync_digit0_dwell", 32'(found), 32'd1);
        write_pat(2'd2, 8'h7F);
        run(2 * FP);
        check("new_digit2_seen", 32'(seen_80 > 0), 32'd1);

        // disable digits 1 and 3
        mask_wr = 1'b1; mask_data = 4'b0101;
        step();
        mask_wr = 1'b0;
        run(2 * FP);

        // write on the frame_tick cycle, then a repeated write with a mask write alongside
        found = 0;
        for (int i = 0; i < 2 * FP && found == 0; i++) begin
            step();
            if (frame_tick) found = 1;
        end
        check("sync_frame_tick", 32'(found), 32'd1);
        write_pat(2'd3, 8'h01);
        run(3);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h02;
        mask_wr = 1'b1; mask_data = 4'b1111;
        step();
        wr_en = 1'b0; mask_wr = 1'b0;
        run(2 * FP);

        // reset during digit 2 dwell
        found = 0;
        for (int i = 0; i < 2 * FP && found == 0; i++) begin
            step();
            if ((k % FP) == 2 * DP + BL + 1) found = 1;
        end
        check("sync_digit2_dwell", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        check("rst_an", 32'(an_out), 32'(4'b1111));
        check("rst_idx", 32'(digit_idx), 32'd0);
        rst = 1'b0;
        run(2 * FP + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
